// File: rtl/key_line_buffer_pkg.sv
// Shared key-code map and line-editor state encoding used by the keyboard
// controller, the line buffer and the evaluator.
package key_line_buffer_pkg;

  localparam logic [7:0] code_null    = 8'd0;
  localparam logic [7:0] code_a       = 8'd1;
  localparam logic [7:0] code_z       = 8'd26;
  localparam logic [7:0] code_A       = 8'd27;
  localparam logic [7:0] code_Z       = 8'd52;
  localparam logic [7:0] code_dollar  = 8'd53;
  localparam logic [7:0] code_lbrace  = 8'd54;
  localparam logic [7:0] code_rbrace  = 8'd55;
  localparam logic [7:0] code_eq      = 8'd56;
  localparam logic [7:0] code_starter = 8'd57;
  localparam logic [7:0] code_lambda  = 8'd58;
  localparam logic [7:0] code_space   = 8'd59;
  localparam logic [7:0] code_dot     = 8'd60;
  localparam logic [7:0] code_end     = 8'd61;
  localparam logic [7:0] code_bksp    = 8'd65;
  localparam logic [7:0] code_enter   = 8'd66;
  localparam logic [7:0] code_up      = 8'd67;
  localparam logic [7:0] code_down    = 8'd68;

  localparam logic [0:0] EDIT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // Printable symbols occupy the contiguous range code_a..code_end.
  function automatic logic is_symbol(input logic [7:0] code);
    return (code >= code_a) && (code <= code_end);
  endfunction

endpackage

// File: rtl/key_line_buffer_ram.sv
// DEPTH x 6-bit symbol store: one write port, two registered read ports.
// Reads return the pre-write contents when they collide with a write.
module line_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [5:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [5:0]        rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [5:0]        rdata_b_o
);

  logic [5:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_o <= mem_q[raddr_a_i];
    rdata_b_o <= mem_q[raddr_b_i];
  end

endmodule

// File: rtl/key_line_buffer.sv
// Line editor: turns key-code edges into symbol writes, backspace, commit and
// scroll pulses, and hands a committed line to the evaluator via valid/ack.
module key_line_buffer
  import key_line_buffer_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic [7:0]        key_code,
  output logic [ADDR_W:0]   line_len,
  output logic              line_valid,
  input  logic              line_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [5:0]        rd_data,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [5:0]        disp_data,
  output logic              scroll_up,
  output logic              scroll_down,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

  logic [7:0]      prev_code_q;
  logic [0:0]      state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            su_q, su_d, sd_q, sd_d, ov_q, ov_d;
  logic            rd_ok_q, disp_ok_q;
  logic            key_evt, we;
  logic [5:0]      ram_rd, ram_disp;

  // A held key fires once: only a change to a non-null code is an event.
  assign key_evt = (key_code != code_null) && (key_code != prev_code_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    su_d    = 1'b0;
    sd_d    = 1'b0;
    ov_d    = 1'b0;
    we      = 1'b0;
    if ((state_q == LOCKED) && line_ack) begin
      len_d   = '0;
      state_d = EDIT;
    end else if (key_evt) begin
      if (key_code == code_up) begin
        su_d = 1'b1;
      end else if (key_code == code_down) begin
        sd_d = 1'b1;
      end else if (state_q == EDIT) begin
        if (is_symbol(key_code)) begin
          if (len_q == FULL_LEN) begin
            ov_d = 1'b1;
          end else begin
            we    = 1'b1;
            len_d = len_q + 1'b1;
          end
        end else if ((key_code == code_bksp) && (len_q != '0)) begin
          len_d = len_q - 1'b1;
        end else if ((key_code == code_enter) && (len_q != '0)) begin
          state_d = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      prev_code_q <= code_null;
      state_q     <= EDIT;
      len_q       <= '0;
      su_q        <= 1'b0;
      sd_q        <= 1'b0;
      ov_q        <= 1'b0;
      rd_ok_q     <= 1'b0;
      disp_ok_q   <= 1'b0;
    end else begin
      prev_code_q <= key_code;
      state_q     <= state_d;
      len_q       <= len_d;
      su_q        <= su_d;
      sd_q        <= sd_d;
      ov_q        <= ov_d;
      rd_ok_q     <= ({1'b0, rd_addr} < len_q);
      disp_ok_q   <= ({1'b0, disp_addr} < len_q);
    end
  end

  line_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_25mhz),
    .we_i      (we),
    .waddr_i   (len_q[ADDR_W-1:0]),
    .wdata_i   (key_code[5:0]),
    .raddr_a_i (rd_addr),
    .rdata_a_o (ram_rd),
    .raddr_b_i (disp_addr),
    .rdata_b_o (ram_disp)
  );

  // Slots at or beyond the cursor read as empty so stale RAM never leaks out.
  assign rd_data     = rd_ok_q ? ram_rd : 6'd0;
  assign disp_data   = disp_ok_q ? ram_disp : 6'd0;
  assign line_len    = len_q;
  assign line_valid  = (state_q == LOCKED);
  assign scroll_up   = su_q;
  assign scroll_down = sd_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_key_line_buffer.sv
// Bench for key_line_buffer: behavioural line model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_key_line_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] key_code;
  logic [5:0] line_len;
  logic       line_valid;
  logic       line_ack;
  logic [4:0] rd_addr;
  logic [5:0] rd_data;
  logic [4:0] disp_addr;
  logic [5:0] disp_data;
  logic       scroll_up, scroll_down, overflow;

  key_line_buffer #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk_25mhz   (clk),
    .reset       (reset),
    .key_code    (key_code),
    .line_len    (line_len),
    .line_valid  (line_valid),
    .line_ack    (line_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .scroll_up   (scroll_up),
    .scroll_down (scroll_down),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;
  int su_cnt = 0, sd_cnt = 0, ov_cnt = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- line model ----------------
  int m_len, m_prev, e_rd, e_disp;
  int m_mem[32];
  bit m_locked, e_su, e_sd, e_ov;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_len = 0; m_prev = 0; m_locked = 0;
    e_rd = 0; e_disp = 0; e_su = 0; e_sd = 0; e_ov = 0;
  end

  always @(posedge clk) begin
    int k;
    bit fire;
    k = int'(key_code);
    if (reset) begin
      m_len = 0; m_locked = 0; m_prev = 0;
      e_rd = 0; e_disp = 0; e_su = 0; e_sd = 0; e_ov = 0;
    end else begin
      e_rd   = (int'(rd_addr) < m_len) ? m_mem[rd_addr] : 0;
      e_disp = (int'(disp_addr) < m_len) ? m_mem[disp_addr] : 0;
      e_su = 0; e_sd = 0; e_ov = 0;
      fire = (k != 0) && (k != m_prev);
      m_prev = k;
      if (m_locked && line_ack) begin
        m_len = 0;
        m_locked = 0;
      end else if (fire) begin
        if (k == 67) e_su = 1;
        else if (k == 68) e_sd = 1;
        else if (!m_locked) begin
          if (k >= 1 && k <= 61) begin
            if (m_len < 32) begin
              m_mem[m_len] = k % 64;
              m_len++;
            end else e_ov = 1;
          end else if (k == 65 && m_len > 0) m_len--;
          else if (k == 66 && m_len > 0) m_locked = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse counting.
  always @(negedge clk) begin
    if (check_en) begin
      check("line_len", int'(line_len), m_len);
      check("line_valid", int'(line_valid), int'(m_locked));
      check("scroll_up", int'(scroll_up), int'(e_su));
      check("scroll_down", int'(scroll_down), int'(e_sd));
      check("overflow", int'(overflow), int'(e_ov));
      check("rd_data", int'(rd_data), e_rd);
      check("disp_data", int'(disp_data), e_disp);
      su_cnt += int'(scroll_up);
      sd_cnt += int'(scroll_down);
      ov_cnt += int'(overflow);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input int c);
    key_code = 8'(c);
    tick();
    key_code = 8'd0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic disp_read(input int addr, input int exp, input string name);
    disp_addr = 5'(addr);
    tick();
    check(name, int'(disp_data), exp);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int su0, sd0, ov0;
    reset = 1'b1; key_code = 8'd0; line_ack = 1'b0;
    rd_addr = 5'd0; disp_addr = 5'd0;
    tick(); tick();
    reset = 1'b0;
    check_en = 1'b1;
    check("reset_len", int'(line_len), 0);
    check("reset_valid", int'(line_valid), 0);
    check("reset_disp", int'(disp_data), 0);

    // Basic typing and display echo.
    key(1); key(2); key(3);
    check("type3_len", int'(line_len), 3);
    exp_q.push_back(6'd1); exp_q.push_back(6'd2);
    exp_q.push_back(6'd3); exp_q.push_back(6'd0);
    for (int a = 0; a < 4; a++) disp_read(a, int'(exp_q.pop_front()), "disp_echo");

    // Held key fires once; back-to-back distinct codes fire twice.
    key_code = 8'd5;
    for (int i = 0; i < 1000; i++) tick();
    key_code = 8'd0; tick();
    check("hold_len", int'(line_len), 4);
    key_code = 8'd5; tick();
    key_code = 8'd7; tick();
    key_code = 8'd0; tick();
    check("b2b_len", int'(line_len), 6);

    // Backspace floors at zero.
    do_reset();
    key(1); key(2);
    key(65); check("bksp1", int'(line_len), 1);
    key(65); check("bksp2", int'(line_len), 0);
    key(65); check("bksp3", int'(line_len), 0);

    // Saturation at 32 with a single overflow pulse on the 33rd symbol.
    do_reset();
    ov0 = ov_cnt;
    for (int i = 0; i < 33; i++) key(i + 1);
    check("sat_len", int'(line_len), 32);
    check("ov_pulses", ov_cnt - ov0, 1);
    rd_addr = 5'd31; tick();
    check("ram31", int'(rd_data), 32);

    // Commit, frozen buffer, then ack alongside a discarded key.
    do_reset();
    key(1); key(2); key(66);
    check("commit_valid", int'(line_valid), 1);
    key(9); key(65);
    check("locked_len", int'(line_len), 2);
    rd_addr = 5'd1; tick();
    check("locked_rd1", int'(rd_data), 2);
    line_ack = 1'b1; key_code = 8'd4; tick();
    line_ack = 1'b0; tick();
    key_code = 8'd0; tick();
    check("ack_valid", int'(line_valid), 0);
    check("ack_len", int'(line_len), 0);
    rd_addr = 5'd0; tick();
    check("ack_rd0", int'(rd_data), 0);

    // Scroll pulses in both states; ignored codes.
    su0 = su_cnt; sd0 = sd_cnt;
    key(67); key(68);
    check("edit_scroll_up", su_cnt - su0, 1);
    check("edit_scroll_dn", sd_cnt - sd0, 1);
    key(62); key(70);
    check("ignored_len", int'(line_len), 0);
    key(1); key(66);
    su0 = su_cnt; sd0 = sd_cnt;
    key(67); key(68);
    check("lock_scroll_up", su_cnt - su0, 1);
    check("lock_scroll_dn", sd_cnt - sd0, 1);
    check("lock_len", int'(line_len), 1);

    // Reset while locked discards the line.
    reset = 1'b1; tick();
    check("rst_lock_valid", int'(line_valid), 0);
    check("rst_lock_len", int'(line_len), 0);
    reset = 1'b0; tick(); tick();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_line_buffer.md
Name: key_line_buffer

Overview:
Consumes the 8-bit key code stream from controller_keyboard and assembles typed symbols into a line buffer.
- Handles backspace, enter-to-commit and up/down scroll requests.
- Exposes a committed line to the downstream evaluator through a valid/ack handshake and two read ports.
- One read port serves the evaluator; the other serves the display so it can echo the line being edited.

Parameters:
DEPTH, 32, maximum symbols per line (power of two).
ADDR_W, 5, log2(DEPTH).

Ports:
clk_25mhz  in  1  system clock.
reset  in  1  synchronous, active-high reset.
key_code  in  8  key code from controller_keyboard; 0 = code_null.
line_len  out  ADDR_W+1  symbols currently held (0..DEPTH); also the cursor position.
line_valid  out  1  committed line available; buffer locked.
line_ack  in  1  consumer done with line; clears buffer.
rd_addr  in  ADDR_W  evaluator read address.
rd_data  out  6  symbol at rd_addr, registered.
disp_addr  in  ADDR_W  display read address.
disp_data  out  6  symbol at disp_addr, registered.
scroll_up  out  1  one-cycle pulse on code_up.
scroll_down  out  1  one-cycle pulse on code_down.
overflow  out  1  one-cycle pulse when a symbol is dropped on a full buffer.

Behaviour:
- Clocking and reset: one clock (clk_25mhz); reset is synchronous and active-high.
  - On reset: line_len=0, line_valid=0, scroll_up=0, scroll_down=0, overflow=0, rd_data=0, disp_data=0, prev_code=0, state=EDIT.
  - RAM contents are not cleared.
- Key event:
  - prev_code registers key_code every cycle.
  - An event fires in cycle n when key_code!=0 and key_code!=prev_code.
  - The effect (line_len, pulses, state) is visible at cycle n+1.
  - A held key produces exactly one event. The same key re-fires only after key_code returns to 0 or changes to another code.
- Code classes:
  - Symbol: 1..61.
  - BKSP: 65.
  - ENTER: 66.
  - UP: 67.
  - DOWN: 68.
  - Codes 62, 63, 64 and above 68 are ignored with no side effects.
- State EDIT:
  - Symbol with line_len<DEPTH: write key_code[5:0] to ram[line_len]; line_len+1.
  - Symbol with line_len==DEPTH: dropped; overflow pulse.
  - BKSP with line_len>0: line_len-1. BKSP with line_len==0: no effect.
  - ENTER with line_len>0: go to LOCKED; line_valid=1. ENTER with line_len==0: ignored.
  - line_ack: ignored.
- State LOCKED:
  - Symbol, BKSP and ENTER events are consumed and ignored; the buffer is frozen.
  - line_ack=1: line_len=0, line_valid=0, state EDIT.
  - A key event in the same cycle as line_ack is discarded. prev_code still updates, so the key does not re-fire.
- UP/DOWN: raise scroll_up or scroll_down for exactly one cycle in either state. They never change the buffer.
- Read ports:
  - rd_data(n+1) = ram[rd_addr(n)] if rd_addr(n)<line_len(n), else 0.
  - disp_data uses the same rule with disp_addr.
  - A write and a read to the same address in one cycle returns the old value.
- Width rules:
  - line_len is ADDR_W+1 bits and never wraps: saturates at DEPTH, floors at 0.
  - RAM write address is line_len[ADDR_W-1:0], used only when line_len<DEPTH.
- Reset mid-operation: a line in LOCKED is discarded, and any pulse in flight is cleared the next cycle.

Decomposition:
- Shared package (key codes):
  - code_null=0, code_a=1, code_z=26, code_A=27, code_Z=52, code_dollar=53, code_lbrace=54, code_rbrace=55, code_eq=56, code_starter=57, code_lambda=58, code_space=59, code_dot=60, code_end=61.
  - code_bksp=65, code_enter=66, code_up=67, code_down=68.
  - controller_keyboard and the evaluator use the same package.
- Package also holds the state encoding EDIT=0, LOCKED=1.
- One sub-module, line_ram: DEPTH x 6 bits, one write port and two registered read ports. The length masking stays in key_line_buffer.

Test Plan:
- Type codes 1, 0, 2, 0, 3: line_len=3; disp_addr 0/1/2 returns 1/2/3 next cycle; disp_addr 3 returns 0.
- Hold key_code=5 for 1000 cycles, then 0: line_len increments by exactly 1. Then 5, 7 back-to-back with no null between: line_len increments by 2.
- From line_len=2, send 65 three times (nulls between): line_len goes 1, 0, 0; no other output changes.
- Type 33 symbols with DEPTH=32: line_len saturates at 32; overflow pulses once, on the 33rd; ram[31] holds the 32nd symbol.
- Type 1, 2, then 66: line_valid=1. Then 9 and 65: line_len stays 2. rd_addr=1 gives rd_data=2. line_ack=1 together with key 4: line_valid=0, line_len=0, and key 4 is not written.
- Send 67 then 68 in both states: single-cycle scroll_up then scroll_down pulses. Codes 62 and 70: no change to any output. Assert reset while LOCKED: line_valid=0 and line_len=0 on the next cycle.
